// File: rtl/sad1_accumulate_stage_pkg.sv
// Shared constants, encodings and saturation helpers for the SAD1 accumulate stage.
package sad_pkg;

    localparam int NUM_LANES       = 16;
    localparam int LANE_W          = 32;
    localparam int LANES_PER_CYCLE = 4;
    localparam int ACC_W           = 36;
    localparam int RES_W           = 32;
    localparam int REG_W           = 5;
    localparam int CNT_W           = 8;
    localparam int VEC_W           = NUM_LANES * LANE_W;
    localparam int GRP_W           = LANES_PER_CYCLE * LANE_W;
    localparam int SUM_W           = LANE_W + $clog2(LANES_PER_CYCLE);
    localparam int LANE_IDX_W      = $clog2(NUM_LANES);

    typedef enum logic [1:0] {
        SAD_NONE     = 2'd0,
        SAD_CMP      = 2'd1,
        SAD_CMP_LAST = 2'd2,
        SAD_WIN      = 2'd3
    } sad_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } sad_state_e;

    function automatic logic sad_overflow(input logic [ACC_W-1:0] acc);
        return (acc[ACC_W-1:RES_W] != {(ACC_W-RES_W){1'b0}});
    endfunction

    // Anything that does not fit in the result width clamps to all ones.
    function automatic logic [RES_W-1:0] sad_saturate(input logic [ACC_W-1:0] acc);
        if (sad_overflow(acc)) begin
            return {RES_W{1'b1}};
        end else begin
            return acc[RES_W-1:0];
        end
    endfunction

endpackage

// File: rtl/sad1_accumulate_stage_if.sv
// Upstream-facing bundle of the SAD1 stage: latched operands in, result and search tracker out.
interface sad1_accumulate_stage_if;
    import sad_pkg::*;

    logic                   InValid;
    logic [1:0]             SadOp;
    logic [VEC_W-1:0]       WinVec;
    logic [VEC_W-1:0]       FrmVec;
    logic [REG_W-1:0]       WriteRegIn;
    logic                   RegWriteIn;

    logic                   Busy;
    logic                   SadValid;
    logic [RES_W-1:0]       SadResult;
    logic                   SadOverflow;
    logic [REG_W-1:0]       SadWriteReg;
    logic                   SadRegWrite;
    logic [RES_W-1:0]       BestSad;
    logic [CNT_W-1:0]       BestIndex;
    logic [CNT_W-1:0]       FrameCount;
    logic                   SearchDone;

    modport master (
        output InValid, SadOp, WinVec, FrmVec, WriteRegIn, RegWriteIn,
        input  Busy, SadValid, SadResult, SadOverflow, SadWriteReg, SadRegWrite,
               BestSad, BestIndex, FrameCount, SearchDone
    );

    modport slave (
        input  InValid, SadOp, WinVec, FrmVec, WriteRegIn, RegWriteIn,
        output Busy, SadValid, SadResult, SadOverflow, SadWriteReg, SadRegWrite,
               BestSad, BestIndex, FrameCount, SearchDone
    );

endinterface

// File: rtl/sad1_accumulate_stage_absdiff_tree.sv
// Combinational sum of absolute differences over one group of LANES_PER_CYCLE lane pairs.
module sad_absdiff_tree
    import sad_pkg::*;
(
    input  logic [GRP_W-1:0] i_win,
    input  logic [GRP_W-1:0] i_frm,
    output logic [SUM_W-1:0] o_sum
);

    logic [LANE_W-1:0] w_diff [LANES_PER_CYCLE];

    for (genvar g = 0; g < LANES_PER_CYCLE; g++) begin : g_lane
        logic [LANE_W-1:0] w_a;
        logic [LANE_W-1:0] w_b;
        assign w_a       = i_win[g*LANE_W +: LANE_W];
        assign w_b       = i_frm[g*LANE_W +: LANE_W];
        // max-min keeps the difference unsigned without a sign bit
        assign w_diff[g] = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
    end

    // Adds the per-lane differences into a width that cannot overflow.
    always_comb begin
        o_sum = {SUM_W{1'b0}};
        for (int i = 0; i < LANES_PER_CYCLE; i++) begin
            o_sum = o_sum + {{(SUM_W-LANE_W){1'b0}}, w_diff[i]};
        end
    end

endmodule

// File: rtl/sad1_accumulate_stage.sv
// SAD1 execution stage: multi-cycle sum of absolute differences with minimum-SAD search tracking.
module sad1_accumulate_stage
    import sad_pkg::*;
(
    input  logic                    Clk,
    input  logic                    Reset,
    sad1_accumulate_stage_if.slave  bus
);

    sad_state_e             r_state;
    logic [VEC_W-1:0]       r_win;
    logic [VEC_W-1:0]       r_frm;
    logic [REG_W-1:0]       r_wreg;
    logic                   r_regwr;
    logic                   r_last_op;
    logic [ACC_W-1:0]       r_acc;
    logic [LANE_IDX_W-1:0]  r_lane_idx;

    logic                   r_busy;
    logic                   r_sad_valid;
    logic [RES_W-1:0]       r_sad_result;
    logic                   r_sad_ovf;
    logic [REG_W-1:0]       r_sad_wreg;
    logic                   r_sad_regwr;
    logic [RES_W-1:0]       r_best_sad;
    logic [CNT_W-1:0]       r_best_idx;
    logic [CNT_W-1:0]       r_frame_cnt;
    logic                   r_search_done;

    sad_op_e                w_op;
    logic [SUM_W-1:0]       w_grp_sum;
    logic [ACC_W-1:0]       w_acc_next;
    logic                   w_last_grp;

    assign w_op       = sad_op_e'(bus.SadOp);
    assign w_acc_next = r_acc + {{(ACC_W-SUM_W){1'b0}}, w_grp_sum};
    assign w_last_grp = (r_lane_idx == LANE_IDX_W'(NUM_LANES - LANES_PER_CYCLE));

    // The latched vectors shift down one group per cycle, so the low group is always the current one.
    sad_absdiff_tree u_tree (
        .i_win (r_win[GRP_W-1:0]),
        .i_frm (r_frm[GRP_W-1:0]),
        .o_sum (w_grp_sum)
    );

    // Stage FSM with all outputs and the search tracker registered.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state       <= ST_IDLE;
            r_win         <= {VEC_W{1'b0}};
            r_frm         <= {VEC_W{1'b0}};
            r_wreg        <= {REG_W{1'b0}};
            r_regwr       <= 1'b0;
            r_last_op     <= 1'b0;
            r_acc         <= {ACC_W{1'b0}};
            r_lane_idx    <= {LANE_IDX_W{1'b0}};
            r_busy        <= 1'b0;
            r_sad_valid   <= 1'b0;
            r_sad_result  <= {RES_W{1'b0}};
            r_sad_ovf     <= 1'b0;
            r_sad_wreg    <= {REG_W{1'b0}};
            r_sad_regwr   <= 1'b0;
            r_best_sad    <= {RES_W{1'b1}};
            r_best_idx    <= {CNT_W{1'b0}};
            r_frame_cnt   <= {CNT_W{1'b0}};
            r_search_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.InValid) begin
                        case (w_op)
                            SAD_WIN: begin
                                r_best_sad  <= {RES_W{1'b1}};
                                r_best_idx  <= {CNT_W{1'b0}};
                                r_frame_cnt <= {CNT_W{1'b0}};
                            end
                            SAD_CMP, SAD_CMP_LAST: begin
                                r_win      <= bus.WinVec;
                                r_frm      <= bus.FrmVec;
                                r_wreg     <= bus.WriteRegIn;
                                r_regwr    <= bus.RegWriteIn;
                                r_last_op  <= (w_op == SAD_CMP_LAST);
                                r_acc      <= {ACC_W{1'b0}};
                                r_lane_idx <= {LANE_IDX_W{1'b0}};
                                r_busy     <= 1'b1;
                                r_state    <= ST_ACCUM;
                            end
                            default: begin
                                r_state <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_ACCUM: begin
                    r_acc      <= w_acc_next;
                    r_win      <= r_win >> GRP_W;
                    r_frm      <= r_frm >> GRP_W;
                    r_lane_idx <= r_lane_idx + LANE_IDX_W'(LANES_PER_CYCLE);
                    // The final sum is folded straight into the result registers so DONE presents it.
                    if (w_last_grp) begin
                        r_state       <= ST_DONE;
                        r_sad_valid   <= 1'b1;
                        r_sad_result  <= sad_saturate(w_acc_next);
                        r_sad_ovf     <= sad_overflow(w_acc_next);
                        r_sad_wreg    <= r_wreg;
                        r_sad_regwr   <= r_regwr;
                        r_search_done <= r_last_op;
                    end else begin
                        r_state <= ST_ACCUM;
                    end
                end

                ST_DONE: begin
                    r_sad_valid   <= 1'b0;
                    r_sad_regwr   <= 1'b0;
                    r_search_done <= 1'b0;
                    r_busy        <= 1'b0;
                    r_state       <= ST_IDLE;
                    // Strict compare: on a tie the earlier frame keeps the minimum.
                    if (r_sad_result < r_best_sad) begin
                        r_best_sad <= r_sad_result;
                        r_best_idx <= r_frame_cnt;
                    end else begin
                        r_best_idx <= r_best_idx;
                    end
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end

                default: begin
                    r_state       <= ST_IDLE;
                    r_busy        <= 1'b0;
                    r_sad_valid   <= 1'b0;
                    r_sad_regwr   <= 1'b0;
                    r_search_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy        = r_busy;
    assign bus.SadValid    = r_sad_valid;
    assign bus.SadResult   = r_sad_result;
    assign bus.SadOverflow = r_sad_ovf;
    assign bus.SadWriteReg = r_sad_wreg;
    assign bus.SadRegWrite = r_sad_regwr;
    assign bus.BestSad     = r_best_sad;
    assign bus.BestIndex   = r_best_idx;
    assign bus.FrameCount  = r_frame_cnt;
    assign bus.SearchDone  = r_search_done;

endmodule
